// File: rtl/barcode_pkg.sv
// rtl/barcode_pkg.sv - shared types and defaults for the barcode frame sequencer
package barcode_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_SETTLE = 3'd3,
        ST_HOLD   = 3'd4
    } scan_state_t;

    // Decoder class encoding on Y
    localparam logic [1:0] CLS_NONE = 2'b00;
    localparam logic [1:0] CLS_A    = 2'b01;
    localparam logic [1:0] CLS_B    = 2'b10;
    localparam logic [1:0] CLS_C    = 2'b11;

    // Default frame geometry
    localparam int DEF_FRAME_LEN  = 33;
    localparam int DEF_SETTLE_CYC = 2;
    localparam int DEF_TIMEOUT    = 15;

endpackage

// File: rtl/barcode_gap_timer.sv
// rtl/barcode_gap_timer.sv - idle-gap counter between scanner samples with terminal flag
module barcode_gap_timer
    import barcode_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_gap_cnt;

    // Count consecutive gap cycles; any sample or leaving STREAM restarts the count
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_gap_cnt <= '0;
        end else if (i_clear) begin
            r_gap_cnt <= '0;
        end else if (i_enable) begin
            r_gap_cnt <= r_gap_cnt + CW'(1);
        end
    end

    // Terminal on the gap cycle whose increment would reach TIMEOUT
    assign o_terminal = i_enable && (r_gap_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/barcode_scan_ctrl.sv
// rtl/barcode_scan_ctrl.sv - barcode decoder frame sequencer (optional timeout: BARCODE_CTRL_TIMEOUT_EN)
module barcode_scan_ctrl
    import barcode_pkg::*;
#(
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Start,
    input  logic       Abort,
    input  logic       BitIn,
    input  logic       BitValid,
    input  logic [1:0] DecY,
    output logic       DecB,
    output logic       DecRst,
    output logic       Busy,
    output logic [1:0] ResY,
    output logic       ResErr,
    output logic       ResValid,
    input  logic       ResReady,
    output logic [7:0] FrameCnt
);

    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_LEN - 1);
    localparam logic [SW-1:0] LAST_SET = SW'(SETTLE_CYC - 1);

    scan_state_t   r_state;
    scan_state_t   w_next;
    logic          r_armed;
    logic [BW-1:0] r_bit_cnt;
    logic [SW-1:0] r_set_cnt;
    logic          r_dec_b;
    logic          r_dec_rst;
    logic          r_busy;
    logic [1:0]    r_res_y;
    logic          r_res_err;
    logic          r_res_valid;
    logic [7:0]    r_frame_cnt;

    logic          w_last_bit;
    logic          w_set_done;
    logic          w_timeout;
    logic          w_capture;

    assign w_last_bit = BitValid && (r_bit_cnt == LAST_BIT);
    assign w_set_done = (r_set_cnt == LAST_SET);

`ifdef BARCODE_CTRL_TIMEOUT_EN
    logic w_gap_clear;
    logic w_gap_en;

    assign w_gap_clear = (r_state != ST_STREAM) || BitValid;
    assign w_gap_en    = (r_state == ST_STREAM) && !BitValid;

    barcode_gap_timer #(
        .TIMEOUT   (TIMEOUT)
    ) u_gap_timer (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .i_clear   (w_gap_clear),
        .i_enable  (w_gap_en),
        .o_terminal(w_timeout)
    );
`else
    // No gap supervision: STREAM waits for samples indefinitely
    assign w_timeout = (TIMEOUT < 0);
`endif

    // Result is captured at the end of settling or on a gap timeout; Abort suppresses it
    assign w_capture = !Abort &&
                       (((r_state == ST_SETTLE) && w_set_done) ||
                        ((r_state == ST_STREAM) && w_timeout));

    // State register; r_armed blocks Start on the first edge after reset release
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_next;
            r_armed <= 1'b1;
        end
    end

    // Next-state logic; Abort overrides every other transition
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (Start && r_armed) w_next = ST_CLEAR;
            ST_CLEAR:  w_next = ST_STREAM;
            ST_STREAM: begin
                if (w_last_bit)     w_next = ST_SETTLE;
                else if (w_timeout) w_next = ST_HOLD;
            end
            ST_SETTLE: if (w_set_done) w_next = ST_HOLD;
            ST_HOLD:   if (ResReady) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (Abort) w_next = ST_IDLE;
    end

    // Sample and settle counters; both restart whenever their state is not active
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_bit_cnt <= '0;
            r_set_cnt <= '0;
        end else begin
            if (r_state == ST_CLEAR) r_bit_cnt <= '0;
            else if ((r_state == ST_STREAM) && BitValid) r_bit_cnt <= r_bit_cnt + BW'(1);
            if (r_state == ST_SETTLE) r_set_cnt <= r_set_cnt + SW'(1);
            else r_set_cnt <= '0;
        end
    end

    // Decoder input follows accepted samples only; held otherwise
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_dec_b <= 1'b0;
        else if ((r_state == ST_STREAM) && BitValid) r_dec_b <= BitIn;
    end

    // Decoder reset and Busy are registered from the next state so they align with it
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_dec_rst <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_dec_rst <= (w_next == ST_IDLE) || (w_next == ST_CLEAR);
            r_busy    <= (w_next != ST_IDLE);
        end
    end

    // Result register, valid/ready handshake and completed-frame counter
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_res_y     <= CLS_NONE;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else if (Abort) begin
            r_res_valid <= 1'b0;
        end else if (w_capture) begin
            r_res_y     <= DecY;
            r_res_err   <= w_timeout;
            r_res_valid <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end else if ((r_state == ST_HOLD) && ResReady) begin
            r_res_valid <= 1'b0;
        end
    end

    assign DecB     = r_dec_b;
    assign DecRst   = r_dec_rst;
    assign Busy     = r_busy;
    assign ResY     = r_res_y;
    assign ResErr   = r_res_err;
    assign ResValid = r_res_valid;
    assign FrameCnt = r_frame_cnt;

endmodule

// File: tb/tb_barcode_scan_ctrl.sv
// tb/tb_barcode_scan_ctrl.sv - scoreboard bench for barcode_scan_ctrl
module tb_barcode_scan_ctrl;
    import barcode_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       Start;
    logic       Abort;
    logic       BitIn;
    logic       BitValid;
    logic [1:0] DecY;
    logic       DecB;
    logic       DecRst;
    logic       Busy;
    logic [1:0] ResY;
    logic       ResErr;
    logic       ResValid;
    logic       ResReady;
    logic [7:0] FrameCnt;

    typedef struct packed {
        logic [1:0] y;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    int         t0     = 0;
    logic [7:0] model_fcnt = 8'd0;
    logic [1:0] dec_cls = CLS_NONE;

    always #5 Clk = ~Clk;

    // Decoder stand-in: Y is the frame's class once out of reset
    assign DecY = DecRst ? CLS_NONE : dec_cls;

    barcode_scan_ctrl dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Start    (Start),
        .Abort    (Abort),
        .BitIn    (BitIn),
        .BitValid (BitValid),
        .DecY     (DecY),
        .DecB     (DecB),
        .DecRst   (DecRst),
        .Busy     (Busy),
        .ResY     (ResY),
        .ResErr   (ResErr),
        .ResValid (ResValid),
        .ResReady (ResReady),
        .FrameCnt (FrameCnt)
    );

    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_decb"},   DecB,     0);
        chk({tag, "_decrst"}, DecRst,   1);
        chk({tag, "_busy"},   Busy,     0);
        chk({tag, "_resy"},   ResY,     0);
        chk({tag, "_reserr"}, ResErr,   0);
        chk({tag, "_valid"},  ResValid, 0);
        chk({tag, "_fcnt"},   FrameCnt, 0);
    endtask

    task automatic start_frame(input logic [1:0] cls, input logic e_err, input bit hold);
        dec_cls = cls;
        sb.push_back('{y: cls, err: e_err, cnt: model_fcnt + 8'd1});
        Start = 1'b1;
        step();
        t0 = cyc;
        chk("start_busy", Busy, 1);
        chk("clear_rst", DecRst, 1);
        if (!hold) Start = 1'b0;
        BitValid = 1'b0;
        step();
        chk("stream_rst", DecRst, 0);
    endtask

    task automatic send_samples(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = 1'($urandom_range(0, 1));
            BitIn    = b;
            BitValid = 1'b1;
            step();
            chk("dec_b", DecB, b);
        end
        BitValid = 1'b0;
    endtask

    task automatic wait_result(input int exp_lat, input int exp_settle);
        exp_t e;
        int   n = 0;
        while (!ResValid && n < 100) begin
            step();
            n++;
        end
        chk("res_valid", ResValid, 1);
        chk("settle_lat", n, exp_settle);
        if (exp_lat > 0) chk("frame_lat", cyc - t0, exp_lat);
        chk("sb_pending", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("res_y", ResY, e.y);
            chk("res_err", ResErr, e.err);
            chk("frame_cnt", FrameCnt, e.cnt);
            model_fcnt = e.cnt;
        end
    endtask

    task automatic handshake();
        ResReady = 1'b1;
        step();
        ResReady = 1'b0;
        chk("hs_busy", Busy, 0);
        chk("hs_valid", ResValid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b0; Start = 1'b1; Abort = 1'b0;
        BitIn = 1'b0; BitValid = 1'b0; ResReady = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk_reset_vals("rst");

        // Start held across reset release: the first edge is ignored
        @(negedge Clk);
        Rst_n = 1'b1;
        step();
        chk("rel_edge_busy", Busy, 0);
        Start = 1'b0;
        step();

        // Nominal frame with backpressure
        start_frame(CLS_B, 1'b0, 1'b0);
        send_samples(33);
        wait_result(36, 2);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", ResValid, 1);
            chk("bp_resy", ResY, CLS_B);
        end
        handshake();

        // Second Start after handshake
        start_frame(CLS_A, 1'b0, 1'b0);
        send_samples(33);
        wait_result(36, 2);
        handshake();

        // Gap of 15 cycles after 5 samples
`ifdef BARCODE_CTRL_TIMEOUT_EN
        start_frame(CLS_C, 1'b1, 1'b0);
        send_samples(5);
        repeat (14) step();
        chk("to_early", ResValid, 0);
        step();
        chk("to_valid", ResValid, 1);
        wait_result(0, 0);
        handshake();
`else
        start_frame(CLS_C, 1'b0, 1'b0);
        send_samples(5);
        repeat (20) step();
        chk("noto_valid", ResValid, 0);
        chk("noto_busy", Busy, 1);
        send_samples(28);
        wait_result(0, 2);
        handshake();
`endif

        // Abort beats ResReady in HOLD
        start_frame(CLS_C, 1'b0, 1'b0);
        send_samples(33);
        wait_result(36, 2);
        Abort = 1'b1; ResReady = 1'b1;
        step();
        Abort = 1'b0; ResReady = 1'b0;
        chk("ab_hold_valid", ResValid, 0);
        chk("ab_hold_busy", Busy, 0);
        chk("ab_hold_fcnt", FrameCnt, model_fcnt);

        // Abort mid-STREAM, then a fresh frame re-clears
        start_frame(CLS_B, 1'b0, 1'b0);
        send_samples(10);
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        void'(sb.pop_back());
        chk("ab_str_busy", Busy, 0);
        chk("ab_str_decrst", DecRst, 1);
        chk("ab_str_valid", ResValid, 0);
        chk("ab_str_fcnt", FrameCnt, model_fcnt);
        start_frame(CLS_B, 1'b0, 1'b0);
        send_samples(33);
        wait_result(36, 2);
        handshake();

        // Asynchronous reset mid-STREAM
        start_frame(CLS_A, 1'b0, 1'b0);
        send_samples(10);
        #2;
        Rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        void'(sb.pop_back());
        model_fcnt = 8'd0;
        step();
        Rst_n = 1'b1;
        step();
        chk("post_rst_busy", Busy, 0);
        chk("post_rst_decrst", DecRst, 1);

        // 256 frames with Start held while busy: counter wraps to 0
        for (int i = 0; i < 256; i++) begin
            start_frame(2'(i), 1'b0, 1'b1);
            send_samples(33);
            wait_result(36, 2);
            Start = 1'b0;
            handshake();
        end
        chk("wrap_fcnt", FrameCnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/barcode_scan_ctrl.md
# barcode_scan_ctrl

Frame sequencer for the barcode decoder (`Barcode`: serial bit in `B`, 2-bit class out `Y`, active-high `Rst`). It accepts a start request, clears the decoder, streams exactly FRAME_LEN qualified scanner samples into it, and waits for the decoder's Moore output to settle. It then captures `Y` into a result register with a valid/ready handshake. It sits between the scanner sampling front-end and the downstream result consumer, and owns the decoder's reset and input.

## Interface
- FRAME_LEN, 33, samples per frame (≥2)
- SETTLE_CYC, 2, cycles from last accepted sample to capture of DecY (≥2)
- TIMEOUT, 15, idle-gap limit in cycles between BitValid pulses (≥1)
- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Start  in  1  begin frame; sampled only in IDLE
- Abort  in  1  return to IDLE from any state
- BitIn  in  1  scanner sample
- BitValid  in  1  BitIn qualifier
- DecY  in  2  decoder output Y
- DecB  out  1  registered decoder input B
- DecRst  out  1  registered decoder reset (active-high)
- Busy  out  1  high in any state except IDLE
- ResY  out  2  captured class
- ResErr  out  1  frame ended by timeout; qualified by ResValid
- ResValid  out  1  result available
- ResReady  in  1  consumer accepts result
- FrameCnt  out  8  completed frames (good or error), wraps 255→0

## Operation
- States: IDLE, CLEAR, STREAM, SETTLE, HOLD.
- IDLE: DecRst=1. Start → CLEAR.
- CLEAR: one cycle. DecRst=1. BitCnt=0, GapCnt=0. → STREAM.
- STREAM: DecRst=0.
  - BitValid: DecB<=BitIn, BitCnt++, GapCnt=0.
  - Accepting sample FRAME_LEN-1 (zero-based) → SETTLE.
  - No BitValid: GapCnt++. GapCnt reaching TIMEOUT → HOLD with ResErr=1, ResY=DecY.
- SETTLE: exactly SETTLE_CYC cycles. BitValid ignored. On the final edge: ResY<=DecY, ResErr<=0, ResValid<=1, FrameCnt++ → HOLD. The timeout exit also increments FrameCnt.
- HOLD: ResY, ResErr and DecB stable. ResValid=1 until an edge with ResReady=1 → IDLE with ResValid=0. Start ignored.
- Abort: any state → IDLE at next edge. ResValid<=0. FrameCnt unchanged. Abort beats ResReady, Start and the last-sample transition.
- Start and BitValid in IDLE: the sample is dropped; the first sample counted is the first one in STREAM.

## Timing
- Reset values: DecB=0, DecRst=1, Busy=0, ResY=0, ResErr=0, ResValid=0, FrameCnt=0. State=IDLE, counters 0.
- Start high at edge T0:
  - CLEAR during T0..T1.
  - DecRst falls after T1.
  - Earliest sample accepted at edge T2.
- Sample accepted at edge k is on DecB from k to the next accepted sample. The decoder latches it at edge k+1.
- Last sample at edge E: capture at edge E+SETTLE_CYC. ResValid high after that edge.
- Minimum frame (continuous BitValid):
  - Start edge to ResValid rise = FRAME_LEN+1+SETTLE_CYC edges.
  - Handshake edge to IDLE: 1 edge.
- All outputs are registered; no combinational input→output path.
- Start in IDLE with Rst_n rising on the same edge: ignored (reset-release edge).

## Configuration
- BARCODE_CTRL_TIMEOUT_EN defined:
  - Gap counter present.
  - Timeout exit as above.
  - ResErr functional.
- Undefined:
  - STREAM waits indefinitely for samples.
  - No gap counter.
  - ResErr tied 0.
  - TIMEOUT unused.

## Structure
- Shared package `barcode_pkg`:
  - state enum `scan_state_t`
  - 2-bit class encoding constants for Y
  - default FRAME_LEN, SETTLE_CYC and TIMEOUT localparams
- One sub-module, `barcode_gap_timer`: GapCnt plus terminal flag, clear/enable inputs. Instantiated only under BARCODE_CTRL_TIMEOUT_EN.
- The FSM and counters stay in barcode_scan_ctrl.

## Test plan
- Reset: Rst_n low mid-STREAM → all outputs at reset values immediately (asynchronous); Busy=0 and DecRst=1 after release.
- Nominal frame: Start, then 33 continuous samples, DecY model returning 2'b10 → ResValid rises 36 edges after Start (FRAME_LEN+1+SETTLE_CYC), ResY=2'b10, ResErr=0, FrameCnt=1.
- Backpressure: ResReady held low 10 cycles → ResY/ResValid stable; one-cycle ResReady → IDLE next edge, Busy=0; a second Start succeeds.
- Timeout (macro on): 5 samples then BitValid low 15 cycles → HOLD with ResErr=1, FrameCnt++. Macro off: same stimulus stays in STREAM; a resumed stream completes normally.
- Abort with ResReady in HOLD on the same edge → IDLE, ResValid=0, FrameCnt unchanged. Abort mid-STREAM → next Start re-clears with a one-cycle CLEAR.
- Wrap: 256 completed frames → FrameCnt returns to 0; Start while Busy ignored throughout.
